// File: rtl/csr_unit.sv
// Machine-mode CSR file: mstatus/mtvec/mepc/mcause/mtval, 64-bit mcycle/minstret,
// NUM_HPM event counters with mcountinhibit, and a combinational trap target.
module csr_unit #(
    parameter int          NUM_HPM     = 4,
    parameter int          NUM_EVT     = 8,
    parameter bit          VECTORED_EN = 1'b1,
    parameter logic [31:0] MTVEC_RST   = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               csr_we,
    input  logic [1:0]         csr_op,
    input  logic [11:0]        csr_reg,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    output logic               csr_illegal,
    input  logic [31:0]        pc,
    input  logic [31:0]        instruction,
    input  logic [31:0]        misaligned_addr,
    input  logic               trap_pending,
    input  logic [31:0]        trap_cause,
    input  logic               trap_finish,
    input  logic               instr_retire,
    input  logic [NUM_EVT-1:0] hpm_event,
    input  logic [31:0]        mip,
    output logic [31:0]        trap_target,
    output logic [31:0]        mepc,
    output logic [31:0]        mie,
    output logic               irq_en
);

    localparam int          HPM_N    = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam logic [31:0] INH_MASK = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic [31:0] r_inhibit;
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;
    logic [63:0] r_hpm_cnt [HPM_N];
    logic [31:0] r_hpm_evt [HPM_N];

    logic [31:0]      w_rdata;
    logic             w_impl;
    logic [31:0]      w_wval;
    logic             w_wr;
    logic             w_trap;
    logic             w_mret;
    logic [HPM_N-1:0] w_hpm_inc;

    // Reserved/unsupported MODE encodings leave the current mode in place.
    function automatic logic [1:0] mtvec_mode(input logic [1:0] wmode, input logic [1:0] cur);
        if (wmode == 2'b00 || (wmode == 2'b01 && VECTORED_EN))
            return wmode;
        return cur;
    endfunction

    always_comb begin
        w_rdata = 32'h0;
        w_impl  = 1'b1;
        case (csr_reg)
            12'h300: w_rdata = {19'h0, 2'b11, 3'b000, r_mstatus_mpie, 3'b000, r_mstatus_mie, 3'b000};
            12'h301: w_rdata = 32'h4000_0100;
            12'h304: w_rdata = r_mie;
            12'h305: w_rdata = r_mtvec;
            12'h310: w_rdata = 32'h0;
            12'h320: w_rdata = r_inhibit;
            12'h340: w_rdata = r_mscratch;
            12'h341: w_rdata = r_mepc;
            12'h342: w_rdata = r_mcause;
            12'h343: w_rdata = r_mtval;
            12'h344: w_rdata = mip;
            12'hF11, 12'hF12, 12'hF13, 12'hF14: w_rdata = 32'h0;
            default: begin
                w_impl = 1'b0;
                // Counter space 0xB00/0xB80/0xC00/0xC80 + 0..31; index 1 (time) is absent.
                if ((csr_reg[11:8] == 4'hB || csr_reg[11:8] == 4'hC) &&
                    csr_reg[6:5] == 2'b00 && csr_reg[4:0] != 5'd1) begin
                    w_impl = 1'b1;
                    if (csr_reg[4:0] == 5'd0)
                        w_rdata = csr_reg[7] ? r_mcycle[63:32] : r_mcycle[31:0];
                    else if (csr_reg[4:0] == 5'd2)
                        w_rdata = csr_reg[7] ? r_minstret[63:32] : r_minstret[31:0];
                    else
                        for (int i = 0; i < NUM_HPM; i++)
                            if (csr_reg[4:0] == 5'(i + 3))
                                w_rdata = csr_reg[7] ? r_hpm_cnt[i][63:32] : r_hpm_cnt[i][31:0];
                end else if (csr_reg[11:5] == 7'b0011_001 && csr_reg[4:0] >= 5'd3) begin
                    w_impl = 1'b1;
                    for (int i = 0; i < NUM_HPM; i++)
                        if (csr_reg[4:0] == 5'(i + 3))
                            w_rdata = r_hpm_evt[i];
                end
            end
        endcase
    end

    always_comb begin
        case (csr_op)
            2'b01:   w_wval = csr_wdata;
            2'b10:   w_wval = w_rdata | csr_wdata;
            2'b11:   w_wval = w_rdata & ~csr_wdata;
            default: w_wval = w_rdata;
        endcase
    end

    always_comb begin
        w_hpm_inc = '0;
        for (int i = 0; i < NUM_HPM; i++)
            for (int k = 1; k <= NUM_EVT; k++)
                if (r_hpm_evt[i] == 32'(k) && hpm_event[k-1])
                    w_hpm_inc[i] = 1'b1;
    end

    assign csr_illegal = !w_impl || (csr_we && csr_reg[11:10] == 2'b11);
    assign w_wr        = csr_we && !csr_illegal;
    assign w_trap      = trap_pending;
    assign w_mret      = trap_finish && !trap_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= 32'h0;
            r_mtvec        <= MTVEC_RST;
            r_mscratch     <= 32'h0;
            r_mepc         <= 32'h0;
            r_mcause       <= 32'h0;
            r_mtval        <= 32'h0;
            r_inhibit      <= 32'h0;
        end else begin
            if (w_wr) begin
                case (csr_reg)
                    12'h304: r_mie      <= w_wval;
                    12'h305: r_mtvec    <= {w_wval[31:2], mtvec_mode(w_wval[1:0], r_mtvec[1:0])};
                    12'h320: r_inhibit  <= w_wval & INH_MASK;
                    12'h340: r_mscratch <= w_wval;
                    default: ;
                endcase
            end
            // Trap entry owns mstatus/mepc/mcause/mtval this cycle; mret owns mstatus.
            if (w_trap) begin
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
                r_mepc         <= {pc[31:2], 2'b00};
                r_mcause       <= trap_cause;
                if (trap_cause == 32'd3)
                    r_mtval <= pc;
                else if (trap_cause == 32'd2)
                    r_mtval <= instruction;
                else if (trap_cause == 32'd0 || trap_cause == 32'd4 || trap_cause == 32'd6)
                    r_mtval <= misaligned_addr;
            end else begin
                if (w_mret) begin
                    r_mstatus_mie  <= r_mstatus_mpie;
                    r_mstatus_mpie <= 1'b1;
                end else if (w_wr && csr_reg == 12'h300) begin
                    r_mstatus_mie  <= w_wval[3];
                    r_mstatus_mpie <= w_wval[7];
                end
                if (w_wr) begin
                    case (csr_reg)
                        12'h341: r_mepc   <= {w_wval[31:2], 2'b00};
                        12'h342: r_mcause <= w_wval;
                        12'h343: r_mtval  <= w_wval;
                        default: ;
                    endcase
                end
            end
        end
    end

    // A software write to either half replaces it and skips that cycle's increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcycle   <= 64'h0;
            r_minstret <= 64'h0;
            for (int i = 0; i < NUM_HPM; i++) begin
                r_hpm_cnt[i] <= 64'h0;
                r_hpm_evt[i] <= 32'h0;
            end
        end else begin
            if (w_wr && csr_reg == 12'hB00)
                r_mcycle[31:0] <= w_wval;
            else if (w_wr && csr_reg == 12'hB80)
                r_mcycle[63:32] <= w_wval;
            else if (!r_inhibit[0])
                r_mcycle <= r_mcycle + 64'd1;

            if (w_wr && csr_reg == 12'hB02)
                r_minstret[31:0] <= w_wval;
            else if (w_wr && csr_reg == 12'hB82)
                r_minstret[63:32] <= w_wval;
            else if (instr_retire && !r_inhibit[2])
                r_minstret <= r_minstret + 64'd1;

            for (int i = 0; i < NUM_HPM; i++) begin
                if (w_wr && csr_reg == 12'hB03 + 12'(i))
                    r_hpm_cnt[i][31:0] <= w_wval;
                else if (w_wr && csr_reg == 12'hB83 + 12'(i))
                    r_hpm_cnt[i][63:32] <= w_wval;
                else if (w_hpm_inc[i] && !r_inhibit[3+i])
                    r_hpm_cnt[i] <= r_hpm_cnt[i] + 64'd1;
                if (w_wr && csr_reg == 12'h323 + 12'(i))
                    r_hpm_evt[i] <= (w_wval > 32'(NUM_EVT)) ? 32'h0 : w_wval;
            end
        end
    end

    assign csr_rdata   = w_rdata;
    assign mepc        = r_mepc;
    assign mie         = r_mie;
    assign irq_en      = r_mstatus_mie;
    assign trap_target = {r_mtvec[31:2], 2'b00} +
                         ((r_mtvec[1:0] == 2'b01 && trap_cause[31]) ? {25'h0, trap_cause[4:0], 2'b00} : 32'h0);

endmodule
